// File: rtl/imm_target_pipe_pkg.sv
// Shared decode definitions for the immediate/jump-target pipe.
// imm_decode always yields a 64-bit immediate, zero-masked above bit 31 when xlen is 32.
package ppu_imm_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [63:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } dec_t;

  function automatic dec_t imm_decode(input logic [31:0] instr, input int unsigned xlen);
    dec_t d;
    logic s;
    s         = instr[31];
    d.imm     = 64'd0;
    d.fmt     = FMT_R;
    d.illegal = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        d.fmt = FMT_I;
        d.imm = {{52{s}}, instr[31:20]};
      end
      OP_STORE: begin
        d.fmt = FMT_S;
        d.imm = {{52{s}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        d.fmt = FMT_B;
        d.imm = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        d.fmt = FMT_U;
        d.imm = {{32{s}}, instr[31:12], 12'd0};
      end
      OP_JAL: begin
        d.fmt = FMT_J;
        d.imm = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_REG: begin
        d.fmt = FMT_R;
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    d.imm = (xlen == 32'd32) ? {32'd0, d.imm[31:0]} : d.imm;
    return d;
  endfunction

endpackage

// File: rtl/imm_target_pipe_stage.sv
// One elastic register slice: a valid bit plus a payload that only changes when a real entry loads.
module imm_pipe_stage
  import ppu_imm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Valid/payload register with synchronous reset; flush only clears valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (load_i) begin
        valid_q <= valid_i;
      end else begin
        valid_q <= valid_q;
      end
      if (load_i && valid_i) begin
        data_q <= data_i;
      end else begin
        data_q <= data_q;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/imm_target_pipe.sv
// Immediate decode and control-transfer target unit followed by DEPTH elastic stages.
// All decode/arithmetic happens ahead of stage 0; later stages only carry the payload.
module imm_target_pipe
  import ppu_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_jump,
  output logic            out_branch,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam int W = 2 * XLEN + 6;

  dec_t            dec_s;
  logic            unused_dec_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] target_s;
  logic            is_jal_s;
  logic            is_jalr_s;
  logic            is_branch_s;
  logic [W-1:0]    pay_in_s;
  logic [W-1:0]    din_s  [DEPTH];
  logic [W-1:0]    dout_s [DEPTH];
  logic [DEPTH-1:0] vin_s;
  logic [DEPTH-1:0] v_s;
  logic [DEPTH:0]   adv_s;

  assign dec_s        = imm_decode(in_instr, XLEN);
  assign imm_s        = dec_s.imm[XLEN-1:0];
  assign unused_dec_s = ^dec_s.imm;
  assign is_jal_s     = (in_instr[6:0] == OP_JAL);
  assign is_jalr_s    = (in_instr[6:0] == OP_JALR);
  assign is_branch_s  = (in_instr[6:0] == OP_BRANCH);

  // Target adder; JALR rebases on rs1 and clears bit 0, sums wrap at XLEN.
  always_comb begin
    target_s = {XLEN{1'b0}};
    if (is_branch_s || is_jal_s) begin
      target_s = in_pc + imm_s;
    end else if (is_jalr_s) begin
      target_s = (in_rs1 + imm_s) & ~{{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      target_s = {XLEN{1'b0}};
    end
  end

  assign pay_in_s = {imm_s, dec_s.fmt, is_jal_s | is_jalr_s, is_branch_s, target_s, dec_s.illegal};

  // Ready chain: a stage may load when it is empty or its successor can load.
  always_comb begin
    adv_s        = {(DEPTH+1){1'b0}};
    adv_s[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv_s[k] = ~v_s[k] | adv_s[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign vin_s[k] = in_valid;
      assign din_s[k] = pay_in_s;
    end else begin : g_rest
      assign vin_s[k] = v_s[k-1];
      assign din_s[k] = dout_s[k-1];
    end

    imm_pipe_stage #(.W(W)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .load_i  (adv_s[k]),
      .valid_i (vin_s[k]),
      .data_i  (din_s[k]),
      .valid_o (v_s[k]),
      .data_o  (dout_s[k])
    );
  end

  assign in_ready  = adv_s[0];
  assign out_valid = v_s[DEPTH-1];
  assign {out_imm, out_fmt, out_jump, out_branch, out_target, out_illegal} = dout_s[DEPTH-1];

endmodule

// File: tb/tb_imm_target_pipe.sv
// Bench for imm_target_pipe in three configurations: directed cases plus random traffic
// scored against a field-arithmetic reference model and per-instance expected-result queues.
module tb_imm_target_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        jump;
    logic        branch;
    logic [63:0] target;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // instance a: XLEN 32, DEPTH 1
  logic        a_fl, a_iv, a_ir, a_ov, a_or, a_jmp, a_br, a_ill;
  logic [31:0] a_ins, a_pc, a_rs1, a_imm, a_tgt;
  logic [2:0]  a_fmt;
  // instance b: XLEN 64, DEPTH 2
  logic        b_fl, b_iv, b_ir, b_ov, b_or, b_jmp, b_br, b_ill;
  logic [31:0] b_ins;
  logic [63:0] b_pc, b_rs1, b_imm, b_tgt;
  logic [2:0]  b_fmt;
  // instance c: XLEN 32, DEPTH 3
  logic        c_fl, c_iv, c_ir, c_ov, c_or, c_jmp, c_br, c_ill;
  logic [31:0] c_ins, c_pc, c_rs1, c_imm, c_tgt;
  logic [2:0]  c_fmt;

  imm_target_pipe #(.XLEN(32), .DEPTH(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_instr(a_ins), .in_pc(a_pc), .in_rs1(a_rs1), .out_valid(a_ov), .out_ready(a_or),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_jump(a_jmp), .out_branch(a_br),
    .out_target(a_tgt), .out_illegal(a_ill));

  imm_target_pipe #(.XLEN(64), .DEPTH(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
    .in_instr(b_ins), .in_pc(b_pc), .in_rs1(b_rs1), .out_valid(b_ov), .out_ready(b_or),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_jump(b_jmp), .out_branch(b_br),
    .out_target(b_tgt), .out_illegal(b_ill));

  imm_target_pipe #(.XLEN(32), .DEPTH(3)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir),
    .in_instr(c_ins), .in_pc(c_pc), .in_rs1(c_rs1), .out_valid(c_ov), .out_ready(c_or),
    .out_imm(c_imm), .out_fmt(c_fmt), .out_jump(c_jmp), .out_branch(c_br),
    .out_target(c_tgt), .out_illegal(c_ill));

  // Reference: immediates rebuilt from instruction fields with signed shifts and weights.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                 input logic [63:0] rs1, input int xlen);
    exp_t        e;
    longint      sx;
    longint      imm;
    logic [63:0] mask;
    logic [6:0]  op;
    op   = ins[6:0];
    sx   = longint'($signed(ins));
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    e    = '0;
    imm  = 0;
    if (op inside {7'h13, 7'h03, 7'h67, 7'h73}) begin
      e.fmt = 3'd1;
      imm   = sx >>> 20;
    end else if (op == 7'h23) begin
      e.fmt = 3'd2;
      imm   = ((sx >>> 25) * 32) + ((sx >>> 7) & 31);
    end else if (op == 7'h63) begin
      e.fmt = 3'd3;
      imm   = ((sx >>> 31) * 4096) + (((sx >>> 7) & 1) * 2048)
            + (((sx >>> 25) & 63) * 32) + (((sx >>> 8) & 15) * 2);
    end else if (op inside {7'h37, 7'h17}) begin
      e.fmt = 3'd4;
      imm   = (sx >>> 12) * 4096;
    end else if (op == 7'h6F) begin
      e.fmt = 3'd5;
      imm   = ((sx >>> 31) * 1048576) + (((sx >>> 12) & 255) * 4096)
            + (((sx >>> 20) & 1) * 2048) + (((sx >>> 21) & 1023) * 2);
    end else if (op == 7'h33) begin
      e.fmt = 3'd0;
    end else begin
      e.illegal = 1'b1;
    end
    e.imm    = 64'(imm) & mask;
    e.jump   = (op == 7'h6F) || (op == 7'h67);
    e.branch = (op == 7'h63);
    if (e.branch || op == 7'h6F) e.target = (pc + 64'(imm)) & mask;
    else if (op == 7'h67)        e.target = (rs1 + 64'(imm)) & mask & ~64'd1;
    return e;
  endfunction

  function automatic exp_t obs32(input logic [31:0] imm, input logic [2:0] fmt, input logic j,
                                 input logic b, input logic [31:0] t, input logic il);
    return {32'd0, imm, fmt, j, b, 32'd0, t, il};
  endfunction

  function automatic exp_t obs64(input logic [63:0] imm, input logic [2:0] fmt, input logic j,
                                 input logic b, input logic [63:0] t, input logic il);
    return {imm, fmt, j, b, t, il};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int          sel;
    r   = $urandom();
    sel = $urandom_range(0, 11);
    case (sel)
      0:  r[6:0] = 7'h13;
      1:  r[6:0] = 7'h03;
      2:  r[6:0] = 7'h67;
      3:  r[6:0] = 7'h73;
      4:  r[6:0] = 7'h23;
      5:  r[6:0] = 7'h63;
      6:  r[6:0] = 7'h37;
      7:  r[6:0] = 7'h17;
      8:  r[6:0] = 7'h6F;
      9:  r[6:0] = 7'h33;
      default: r = r;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic sb(input int id, input logic iv, input logic ir, input logic ov, input logic ordy,
                    input logic fl, input exp_t obs, input exp_t nxt);
    exp_t e;
    int   n;
    case (id)
      0:       n = qa.size();
      1:       n = qb.size();
      default: n = qc.size();
    endcase
    if (ov && ordy && !fl) begin
      tests++;
      assert (n > 0) else begin
        fails++;
        $error("FAIL sb%0d_spurious: got output %h, required none", id, obs);
      end
      if (n > 0) begin
        case (id)
          0:       e = qa.pop_front();
          1:       e = qb.pop_front();
          default: e = qc.pop_front();
        endcase
        tests++;
        assert (obs === e) else begin
          fails++;
          $error("FAIL sb%0d_payload: got %h, required %h", id, obs, e);
        end
      end
    end
    if (fl) begin
      case (id)
        0:       qa.delete();
        1:       qb.delete();
        default: qc.delete();
      endcase
    end else if (iv && ir) begin
      case (id)
        0:       qa.push_back(nxt);
        1:       qb.push_back(nxt);
        default: qc.push_back(nxt);
      endcase
    end
  endtask

  // Sample handshakes at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      qc.delete();
    end else begin
      sb(0, a_iv, a_ir, a_ov, a_or, a_fl, obs32(a_imm, a_fmt, a_jmp, a_br, a_tgt, a_ill),
         model(a_ins, {32'd0, a_pc}, {32'd0, a_rs1}, 32));
      sb(1, b_iv, b_ir, b_ov, b_or, b_fl, obs64(b_imm, b_fmt, b_jmp, b_br, b_tgt, b_ill),
         model(b_ins, b_pc, b_rs1, 64));
      sb(2, c_iv, c_ir, c_ov, c_or, c_fl, obs32(c_imm, c_fmt, c_jmp, c_br, c_tgt, c_ill),
         model(c_ins, {32'd0, c_pc}, {32'd0, c_rs1}, 32));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent;
    logic acc;
    rst_n = 1'b0;
    {a_fl, a_iv, b_fl, b_iv, c_fl, c_iv} = 6'd0;
    {a_or, b_or, c_or} = 3'b111;
    a_ins = 32'd0; a_pc = 32'd0; a_rs1 = 32'd0;
    b_ins = 32'd0; b_pc = 64'd0; b_rs1 = 64'd0;
    c_ins = 32'd0; c_pc = 32'd0; c_rs1 = 32'd0;
    tick();
    tick();
    chk("rst_a_valid", 64'(a_ov), 64'd0);
    chk("rst_a_imm", 64'(a_imm), 64'd0);
    chk("rst_a_target", 64'(a_tgt), 64'd0);
    chk("rst_a_fmt", 64'(a_fmt), 64'd0);
    chk("rst_a_in_ready", 64'(a_ir), 64'd1);
    chk("rst_b_valid", 64'(b_ov), 64'd0);
    chk("rst_c_in_ready", 64'(c_ir), 64'd1);
    rst_n = 1'b1;

    // B-type with negative offset
    a_iv = 1'b1; a_ins = 32'hFE00_0EE3; a_pc = 32'h100;
    tick();
    a_iv = 1'b0;
    chk("t1_valid", 64'(a_ov), 64'd1);
    chk("t1_imm", 64'(a_imm), 64'hFFFF_FFFC);
    chk("t1_fmt", 64'(a_fmt), 64'd3);
    chk("t1_branch", 64'(a_br), 64'd1);
    chk("t1_target", 64'(a_tgt), 64'h0000_00FC);

    // JAL then JALR
    a_iv = 1'b1; a_ins = 32'h0010_00EF; a_pc = 32'h1000;
    tick();
    chk("t2_jal_imm", 64'(a_imm), 64'h800);
    chk("t2_jal_jump", 64'(a_jmp), 64'd1);
    chk("t2_jal_target", 64'(a_tgt), 64'h1800);
    a_ins = 32'hFFF0_8067; a_rs1 = 32'h2003;
    tick();
    a_iv = 1'b0;
    chk("t2_jalr_imm", 64'(a_imm), 64'hFFFF_FFFF);
    chk("t2_jalr_jump", 64'(a_jmp), 64'd1);
    chk("t2_jalr_target", 64'(a_tgt), 64'h2002);
    tick();

    // XLEN 64: LUI sign extension, then an illegal opcode
    b_iv = 1'b1; b_ins = 32'h8000_00B7; b_pc = 64'd0;
    tick();
    chk("t3_latency_not_yet", 64'(b_ov), 64'd0);
    b_ins = 32'h0000_007F;
    tick();
    b_iv = 1'b0;
    chk("t3_lui_valid", 64'(b_ov), 64'd1);
    chk("t3_lui_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    chk("t3_lui_fmt", 64'(b_fmt), 64'd4);
    tick();
    chk("t3_ill_valid", 64'(b_ov), 64'd1);
    chk("t3_ill_flag", 64'(b_ill), 64'd1);
    chk("t3_ill_imm", b_imm, 64'd0);
    chk("t3_ill_fmt", 64'(b_fmt), 64'd0);
    tick();

    // DEPTH 2 backpressure: out_ready low for cycles 2..4 of a 5-entry stream
    sent = 0;
    for (int cyc = 0; cyc < 40 && (sent < 5 || qb.size() > 0 || b_ov); cyc++) begin
      b_or  = !(cyc >= 2 && cyc <= 4);
      b_iv  = (sent < 5);
      b_ins = rnd_instr();
      b_pc  = {$urandom(), $urandom()};
      b_rs1 = {$urandom(), $urandom()};
      #1;
      if (cyc == 2) chk("t4_full_in_ready", 64'(b_ir), 64'd0);
      acc = b_iv && b_ir;
      tick();
      if (acc) sent++;
    end
    b_iv = 1'b0; b_or = 1'b1;
    chk("t4_sent", 64'(sent), 64'd5);
    chk("t4_drained", 64'(qb.size()), 64'd0);

    // DEPTH 3 flush with three entries in flight and a new input offered
    for (int i = 0; i < 3; i++) begin
      c_iv = 1'b1; c_ins = rnd_instr(); c_pc = $urandom(); c_rs1 = $urandom();
      tick();
    end
    chk("t5_inflight_valid", 64'(c_ov), 64'd1);
    c_fl = 1'b1; c_iv = 1'b1; c_ins = 32'h0000_0537;
    tick();
    c_fl = 1'b0; c_iv = 1'b0;
    chk("t5_after_flush_valid", 64'(c_ov), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_flushed_input_absent", 64'(c_ov), 64'd0);
    end

    // Reset mid-stream, then a fresh input must take exactly DEPTH cycles
    c_iv = 1'b1; c_ins = rnd_instr();
    tick();
    tick();
    c_iv = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_valid", 64'(c_ov), 64'd0);
    chk("t6_rst_imm", 64'(c_imm), 64'd0);
    chk("t6_rst_in_ready", 64'(c_ir), 64'd1);
    c_iv = 1'b1; c_ins = 32'h00A0_0093;
    tick();
    c_iv = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      chk("t6_latency", 64'(c_ov), (t == 3) ? 64'd1 : 64'd0);
      if (t < 3) tick();
    end
    chk("t6_imm", 64'(c_imm), 64'd10);
    tick();

    // Random traffic on all three instances
    for (int i = 0; i < 400; i++) begin
      a_iv = ($urandom_range(0, 3) != 0); a_or = ($urandom_range(0, 3) != 0);
      a_ins = rnd_instr(); a_pc = $urandom(); a_rs1 = $urandom();
      b_iv = ($urandom_range(0, 3) != 0); b_or = ($urandom_range(0, 2) != 0);
      b_ins = rnd_instr(); b_pc = {$urandom(), $urandom()}; b_rs1 = {$urandom(), $urandom()};
      c_iv = ($urandom_range(0, 3) != 0); c_or = ($urandom_range(0, 1) != 0);
      c_ins = rnd_instr(); c_pc = $urandom(); c_rs1 = $urandom();
      c_fl = ($urandom_range(0, 15) == 0);
      tick();
    end
    {a_iv, b_iv, c_iv, c_fl} = 4'd0;
    {a_or, b_or, c_or} = 3'b111;
    repeat (6) tick();
    chk("rnd_a_drained", 64'(qa.size()), 64'd0);
    chk("rnd_b_drained", 64'(qb.size()), 64'd0);
    chk("rnd_c_drained", 64'(qc.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
